rv32_pc_controller: RTL and testbench
=====================================

RV32_PC_CONTROLLER -- requirements
Module: rv32_pc_controller

Interface
Parameters (name, default, meaning):
REQ-001 DWIDTH, 32: width of all address ports, in bits.
REQ-002 RESET_VECTOR, 32'h0000_0000: value loaded into PC by reset.
REQ-003 TRAP_VECTOR, 32'h0000_0010: value loaded into PC on a misalignment trap (only when PC_MISALIGN_TRAP_EN is defined).

Ports (name, direction, width, meaning):
REQ-004 Clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 N_Rst, input, 1: reset, synchronous and active-high despite the legacy name.
REQ-006 PCin, input, DWIDTH: next-PC value from the datapath.
REQ-007 Stall, input, 1: 1 = hold PC; 0 = update PC.
REQ-008 PC, output, DWIDTH: registered current program counter.
REQ-009 PCPlus4, output, DWIDTH: combinational PC + 4.
REQ-010 PCPrev, output, DWIDTH: registered PC value before the most recent update.
REQ-011 Misalign, output, 1: registered pulse on a misaligned-load attempt.

Function
REQ-012 On each rising Clk edge with N_Rst=0 and Stall=0, PC shall take PCin, with 1-cycle latency.
REQ-013 With Stall=1 and N_Rst=0, PC and PCPrev shall hold, and Misalign shall be 0.
REQ-014 On every PC update, PCPrev shall take the old PC value.
REQ-015 PCPlus4 = PC + 4, modulo 2^DWIDTH, so all-ones minus 3 wraps to 0; there is no carry out.
REQ-016 Between clock edges, PC shall not change when PCin changes; there is no combinational PCin-to-PC path.
REQ-017 If PCin equals the current PC, the update still occurs, and PCPrev is loaded with that same value.
REQ-018 A misaligned PCin is one with PCin[1:0] != 2'b00; its handling is set by the Configuration section.
REQ-019 Misalign is high for exactly the one cycle following the offending edge; it is 0 otherwise.

Reset
REQ-020 On a rising Clk edge with N_Rst=1: PC <= RESET_VECTOR, PCPrev <= RESET_VECTOR, Misalign <= 0.
REQ-021 Reset overrides Stall and PCin on the same edge.
REQ-022 Reset asserted mid-operation takes effect at the next edge; there is no asynchronous effect.
REQ-023 PCPlus4 equals RESET_VECTOR + 4 after reset.

Configuration
REQ-024 When macro PC_MISALIGN_TRAP_EN is defined and an edge has N_Rst=0, Stall=0 and misaligned PCin:
- PC <= TRAP_VECTOR.
- PCPrev <= old PC.
- Misalign <= 1.
REQ-025 When PC_MISALIGN_TRAP_EN is undefined:
- PCin is loaded unchanged even if misaligned.
- Misalign is tied to 0.
- TRAP_VECTOR is unused.

Verification
REQ-026 Hold N_Rst=1 for 1 edge -> PC=0, PCPrev=0, PCPlus4=4, Misalign=0.
REQ-027 N_Rst=0, Stall=0, PCin=32'h5A5A5A58, 1 edge -> PC=5A5A5A58, PCPlus4=5A5A5A5C; then PCin=32'h00000100, 1 edge -> PC=100, PCPrev=5A5A5A58.
REQ-028 Change PCin between edges -> PC unchanged until the next edge; set Stall=1 for 3 edges -> PC and PCPrev constant.
REQ-029 PC=32'hFFFFFFFC -> PCPlus4=0; assert N_Rst=1 together with Stall=1 -> PC=0 after that edge.
REQ-030 PCin=32'hA5A5A5A5, 1 edge:
- Macro undefined -> PC=A5A5A5A5, Misalign=0.
- Macro defined -> PC=TRAP_VECTOR (10), Misalign=1 for 1 cycle, then 0 on the next aligned load.

Source files
------------

// File: rtl/rv32_pc_controller_if.sv
// PC controller bus: next-PC request from the datapath and the registered PC view back to it.
interface rv32_pc_controller_if #(
    parameter int unsigned DWIDTH = 32
);
    logic [DWIDTH-1:0] PCin;
    logic              Stall;
    logic [DWIDTH-1:0] PC;
    logic [DWIDTH-1:0] PCPlus4;
    logic [DWIDTH-1:0] PCPrev;
    logic              Misalign;

    modport master (
        output PCin, Stall,
        input  PC, PCPlus4, PCPrev, Misalign
    );

    modport slave (
        input  PCin, Stall,
        output PC, PCPlus4, PCPrev, Misalign
    );
endinterface

// File: rtl/rv32_pc_controller.sv
// RV32 program counter register with previous-PC tracking and PC+4 adder.
// Define PC_MISALIGN_TRAP_EN to redirect misaligned next-PC values to TRAP_VECTOR.
module rv32_pc_controller #(
    parameter int unsigned       DWIDTH       = 32,
    parameter logic [DWIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [DWIDTH-1:0] TRAP_VECTOR  = 32'h0000_0010
) (
    input logic                 Clk,
    input logic                 N_Rst,
    rv32_pc_controller_if.slave bus
);

    logic [DWIDTH-1:0] pc_q;
    logic [DWIDTH-1:0] pc_d;
    logic [DWIDTH-1:0] pc_prev_q;
    logic              misalign_d;

    always_comb begin
        pc_d       = bus.PCin;
        misalign_d = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        if (bus.PCin[1:0] != 2'b00) begin
            pc_d       = TRAP_VECTOR;
            misalign_d = 1'b1;
        end
`endif
    end

    // N_Rst is active-high despite its name.
    always_ff @(posedge Clk) begin
        if (N_Rst) begin
            pc_q      <= RESET_VECTOR;
            pc_prev_q <= RESET_VECTOR;
        end else if (!bus.Stall) begin
            pc_q      <= pc_d;
            pc_prev_q <= pc_q;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_q;

    // One-cycle pulse: cleared on any edge that is not a trapping update.
    always_ff @(posedge Clk) begin
        if (N_Rst || bus.Stall) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign bus.Misalign = misalign_q;
`else
    logic unused_trap;
    assign unused_trap  = ^{TRAP_VECTOR, misalign_d};
    assign bus.Misalign = 1'b0;
`endif

    assign bus.PC      = pc_q;
    assign bus.PCPrev  = pc_prev_q;
    assign bus.PCPlus4 = pc_q + {{(DWIDTH-3){1'b0}}, 3'd4};

endmodule

// File: tb/tb_rv32_pc_controller.sv
// Randomized bench for rv32_pc_controller against a PC-history model, plus directed literal checks.
module tb_rv32_pc_controller;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0010;
`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    rv32_pc_controller_if #(.DWIDTH(32)) bus ();

    rv32_pc_controller #(
        .DWIDTH      (32),
        .RESET_VECTOR(RV),
        .TRAP_VECTOR (TV)
    ) dut (
        .Clk  (clk),
        .N_Rst(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the sequence of values PC has held since reset; PC is the newest, PCPrev the one before.
    logic [31:0] hist[$];
    logic        exp_mis;
    bit          model_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] plus4(input logic [31:0] v);
        logic [63:0] s;
        s = (64'(v) + 64'd4) % 64'h1_0000_0000;
        return s[31:0];
    endfunction

    // Apply one cycle of inputs, let the edge happen, then advance the model.
    task automatic step(input logic r, input logic s, input logic [31:0] d);
        rst          = r;
        bus.Stall    = s;
        bus.PCin     = d;
        @(posedge clk);
        if (r) begin
            hist.delete();
            hist.push_back(RV);
            hist.push_back(RV);
            exp_mis  = 1'b0;
            model_on = 1'b1;
        end else if (!s) begin
            if (TRAP_EN && d[1:0] != 2'b00) begin
                hist.push_back(TV);
                exp_mis = 1'b1;
            end else begin
                hist.push_back(d);
                exp_mis = 1'b0;
            end
            void'(hist.pop_front());
        end else begin
            exp_mis = 1'b0;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            chk("pc", bus.PC, hist[1]);
            chk("pc_prev", bus.PCPrev, hist[0]);
            chk("pc_plus4", bus.PCPlus4, plus4(hist[1]));
            chk("misalign", {31'b0, bus.Misalign}, {31'b0, exp_mis});
        end
    end

    initial begin
        logic [31:0] d;
        rst       = 1'b0;
        bus.Stall = 1'b0;
        bus.PCin  = 32'h0;
        #2;

        step(1'b1, 1'b0, 32'h1234_5670);
        chk("rst_pc", bus.PC, 32'h0);
        chk("rst_prev", bus.PCPrev, 32'h0);
        chk("rst_plus4", bus.PCPlus4, 32'h4);
        chk("rst_mis", {31'b0, bus.Misalign}, 32'h0);

        step(1'b0, 1'b0, 32'h5A5A_5A58);
        chk("load1_pc", bus.PC, 32'h5A5A_5A58);
        chk("load1_plus4", bus.PCPlus4, 32'h5A5A_5A5C);
        step(1'b0, 1'b0, 32'h0000_0100);
        chk("load2_pc", bus.PC, 32'h0000_0100);
        chk("load2_prev", bus.PCPrev, 32'h5A5A_5A58);

        // PCin wiggles between edges must not reach PC.
        bus.PCin = 32'hDEAD_BEE0;
        #2;
        chk("no_comb_path", bus.PC, 32'h0000_0100);

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, $urandom & 32'hFFFF_FFFC);
            chk("stall_pc", bus.PC, 32'h0000_0100);
            chk("stall_prev", bus.PCPrev, 32'h5A5A_5A58);
        end

        step(1'b0, 1'b0, 32'h0000_0100);
        chk("same_pc", bus.PC, 32'h0000_0100);
        chk("same_prev", bus.PCPrev, 32'h0000_0100);

        step(1'b0, 1'b0, 32'hFFFF_FFFC);
        chk("wrap_plus4", bus.PCPlus4, 32'h0);
        step(1'b1, 1'b1, 32'h1234_5678);
        chk("rst_over_stall", bus.PC, 32'h0);

        step(1'b0, 1'b0, 32'hA5A5_A5A5);
        if (TRAP_EN) begin
            chk("mis_pc", bus.PC, 32'h0000_0010);
            chk("mis_flag", {31'b0, bus.Misalign}, 32'h1);
        end else begin
            chk("mis_pc", bus.PC, 32'hA5A5_A5A5);
            chk("mis_flag", {31'b0, bus.Misalign}, 32'h0);
        end
        step(1'b0, 1'b0, 32'h0000_0200);
        chk("after_mis_flag", {31'b0, bus.Misalign}, 32'h0);
        chk("after_mis_pc", bus.PC, 32'h0000_0200);

        for (int i = 0; i < 400; i++) begin
            d = $urandom;
            if ($urandom_range(3) != 0) d[1:0] = 2'b00;
            if ($urandom_range(15) == 0) d = 32'hFFFF_FFFC;
            step($urandom_range(31) == 0, $urandom_range(3) == 0, d);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
